// File: rtl/btn_press_decoder.sv
// btn_press_decoder: debounces a synchronised button level and emits
// single-cycle press / long-press / release pulses plus the debounced level.
// The release output is named release_o because "release" is a reserved
// word in SystemVerilog.
module btn_press_decoder #(
    parameter int DEBOUNCE = 4,
    parameter int LONG     = 16,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic syncBtn,
    output logic press,
    output logic longPress,
    output logic release_o,
    output logic level
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARMING    = 3'd1,
        HELD      = 3'd2,
        LONG_HELD = 3'd3,
        DISARMING = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_C  = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG);
    // A counter equal to *_M1 means this edge is the one that reaches the limit.
    localparam logic [CNT_W-1:0] DEB_M1  = DEB_C - ONE;
    localparam logic [CNT_W-1:0] LONG_M1 = LONG_C - ONE;

    state_t           state_q;
    logic [CNT_W-1:0] dcnt_q;
    logic [CNT_W-1:0] hcnt_q;
    logic             longDone_q;
    logic             press_q;
    logic             long_q;
    logic             rel_q;
    logic             level_q;

    // Long-press condition: this edge brings hcnt to LONG and it has not fired yet.
    logic long_hit;
    assign long_hit = (hcnt_q == LONG_M1) && !longDone_q;

    // Debounce/hold FSM with all outputs registered; pulses default low each cycle.
    always_ff @(posedge clk) begin
        press_q <= 1'b0;
        long_q  <= 1'b0;
        rel_q   <= 1'b0;
        if (rst) begin
            state_q    <= IDLE;
            dcnt_q     <= '0;
            hcnt_q     <= '0;
            longDone_q <= 1'b0;
            level_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (syncBtn) begin
                        if (DEB_C == ONE) begin
                            state_q    <= HELD;
                            press_q    <= 1'b1;
                            level_q    <= 1'b1;
                            hcnt_q     <= '0;
                            longDone_q <= 1'b0;
                            dcnt_q     <= '0;
                        end else begin
                            state_q <= ARMING;
                            dcnt_q  <= ONE;
                        end
                    end
                end
                ARMING: begin
                    if (!syncBtn) begin
                        state_q <= IDLE;
                        dcnt_q  <= '0;
                    end else if (dcnt_q == DEB_M1) begin
                        state_q    <= HELD;
                        press_q    <= 1'b1;
                        level_q    <= 1'b1;
                        hcnt_q     <= '0;
                        longDone_q <= 1'b0;
                        dcnt_q     <= '0;
                    end else begin
                        dcnt_q <= dcnt_q + ONE;
                    end
                end
                HELD, LONG_HELD: begin
                    // hcnt counts every edge spent in a held state, saturating at LONG;
                    // the edge that leaves for DISARMING still counts.
                    if (hcnt_q != LONG_C)
                        hcnt_q <= hcnt_q + ONE;
                    if (long_hit) begin
                        long_q     <= 1'b1;
                        longDone_q <= 1'b1;
                    end
                    if (!syncBtn) begin
                        if (DEB_C == ONE) begin
                            state_q <= IDLE;
                            rel_q   <= 1'b1;
                            level_q <= 1'b0;
                            dcnt_q  <= '0;
                        end else begin
                            state_q <= DISARMING;
                            dcnt_q  <= ONE;
                        end
                    end else if (long_hit) begin
                        state_q <= LONG_HELD;
                    end
                end
                DISARMING: begin
                    // hcnt is frozen here so a bounce only delays the long press.
                    if (syncBtn) begin
                        state_q <= longDone_q ? LONG_HELD : HELD;
                        dcnt_q  <= '0;
                    end else if (dcnt_q == DEB_M1) begin
                        state_q <= IDLE;
                        rel_q   <= 1'b1;
                        level_q <= 1'b0;
                        dcnt_q  <= '0;
                    end else begin
                        dcnt_q <= dcnt_q + ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    dcnt_q  <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign press     = press_q;
    assign longPress = long_q;
    assign release_o = rel_q;
    assign level     = level_q;

endmodule
